// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and helpers for the 7-segment scan controller
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;
    typedef logic [7:0] seg_t;

    localparam seg_t       SEG_BLANK = 8'h00;
    localparam logic [3:0] DIG_NONE  = 4'hF;

    function automatic seg_t digit_seg(input logic [31:0] frame, input logic [1:0] idx);
        return frame[{idx, 3'b000} +: 8];
    endfunction

    // Active-low one-cold digit select.
    function automatic logic [3:0] dig_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// rtl/seg7_slot_timer.sv - per-slot cycle counter with blank/on/slot end strobes
module seg7_slot_timer #(
    parameter int SCAN_DIV  = 6750,
    parameter int BLANK_CYC = 64
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clear,
    input  logic [3:0] b_l,
    output logic       blank_end,
    output logic       on_end,
    output logic       slot_end
);

    localparam int CW      = $clog2(SCAN_DIV);
    localparam int W       = CW + 1;
    localparam int ON_STEP = (SCAN_DIV - BLANK_CYC) / 15;

    logic [CW-1:0] cnt;
    logic [W-1:0]  on_len;
    logic [W-1:0]  on_last;

    // One extra bit keeps BLANK_CYC + 15*ON_STEP from wrapping.
    assign on_len  = W'(b_l) * W'(ON_STEP);
    assign on_last = W'(BLANK_CYC) + on_len - W'(1);

    assign blank_end = (cnt == CW'(BLANK_CYC - 1));
    assign on_end    = ({1'b0, cnt} == on_last);
    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clear || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit 7-segment scan controller with double-buffered frames and PWM brightness
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 6750,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic [3:0]  bright,
    input  logic [31:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output seg_t        seg,
    output logic [3:0]  dig,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    state_t      state;
    logic [3:0]  b_l;
    logic [31:0] active_frame;
    logic [31:0] pend_frame;
    logic        clear;
    logic        blank_end;
    logic        on_end;
    logic        slot_end;
    logic        frame_swap;
    logic [1:0]  next_idx;

    assign clear      = (state == IDLE) || !enable;
    assign frame_swap = slot_end && (digit_idx == 2'd3) && (state != IDLE);
    assign next_idx   = digit_idx + 2'd1;

    seg7_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .nrst      (nrst),
        .clear     (clear),
        .b_l       (b_l),
        .blank_end (blank_end),
        .on_end    (on_end),
        .slot_end  (slot_end)
    );

    // frame_ready low doubles as the pending-valid flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            active_frame <= '0;
            pend_frame   <= '0;
            frame_ready  <= 1'b1;
        end else if (!frame_ready && (frame_swap || state == IDLE)) begin
            active_frame <= pend_frame;
            frame_ready  <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            pend_frame  <= frame_in;
            frame_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            b_l         <= '0;
            digit_idx   <= '0;
            seg         <= SEG_BLANK;
            dig         <= DIG_NONE;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                digit_idx <= '0;
                seg       <= SEG_BLANK;
                dig       <= DIG_NONE;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= BLANK;
                        digit_idx   <= '0;
                        b_l         <= bright;
                        frame_start <= 1'b1;
                    end
                    BLANK: begin
                        if (blank_end) begin
                            if (b_l != 4'd0) begin
                                state <= ON;
                                seg   <= digit_seg(active_frame, digit_idx);
                                dig   <= dig_sel(digit_idx);
                            end else begin
                                state <= OFF;
                            end
                        end
                    end
                    ON: begin
                        if (on_end) begin
                            seg <= SEG_BLANK;
                            dig <= DIG_NONE;
                            if (slot_end) begin
                                state       <= BLANK;
                                digit_idx   <= next_idx;
                                b_l         <= bright;
                                frame_start <= (next_idx == 2'd0);
                            end else begin
                                state <= OFF;
                            end
                        end
                    end
                    OFF: begin
                        if (slot_end) begin
                            state       <= BLANK;
                            digit_idx   <= next_idx;
                            b_l         <= bright;
                            frame_start <= (next_idx == 2'd0);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        seg   <= SEG_BLANK;
                        dig   <= DIG_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    localparam int SCAN_DIV  = 32;
    localparam int BLANK_CYC = 2;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] seg;
        logic [3:0] dig;
        int         on;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [3:0]  bright;
    logic [31:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .enable      (enable),
        .bright      (bright),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .seg         (seg),
        .dig         (dig),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic expect_frame(input logic [31:0] frame, input int on);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.idx = 2'(d);
            e.seg = (on > 0) ? frame[8*d +: 8] : 8'h00;
            e.dig = ~(4'b0001 << d);
            e.on  = on;
            sb.push_back(e);
        end
    endtask

    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 300);
        if (frame_start !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL wait_frame_start: no pulse within %0d cycles", n);
        end
    endtask

    // Samples one full slot starting at its first cycle and ends on the next slot's first cycle.
    task automatic capture_slot(input int chg_cyc, input logic [3:0] chg_val);
        exp_t       e;
        int         on_cnt = 0;
        int         first_on = -1;
        int         exp_first;
        logic       seg_bad = 1'b0, dig_bad = 1'b0, idx_bad = 1'b0;
        logic [7:0] bad_seg = 8'h00;
        logic [3:0] bad_dig = 4'h0;
        logic [1:0] bad_idx = 2'd0;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: no expected slot queued");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < SCAN_DIV; i++) begin
            if (dig !== 4'hF) begin
                on_cnt++;
                if (first_on < 0) first_on = i;
                if (dig !== e.dig) begin dig_bad = 1'b1; bad_dig = dig; end
                if (seg !== e.seg) begin seg_bad = 1'b1; bad_seg = seg; end
            end else if (seg !== 8'h00) begin
                seg_bad = 1'b1;
                bad_seg = seg;
            end
            if (digit_idx !== e.idx) begin idx_bad = 1'b1; bad_idx = digit_idx; end
            if (i == chg_cyc) bright = chg_val;
            if (i == 1) frame_valid = 1'b0;
            @(negedge clk);
        end
        exp_first = (e.on > 0) ? BLANK_CYC : -1;
        checks += 5;
        if (on_cnt !== e.on * 2) begin
            errors++;
            $display("FAIL slot%0d_on_cycles: got %0d want %0d", e.idx, on_cnt, e.on * 2);
        end
        if (first_on !== exp_first) begin
            errors++;
            $display("FAIL slot%0d_first_on: got %0d want %0d", e.idx, first_on, exp_first);
        end
        if (seg_bad) begin
            errors++;
            $display("FAIL slot%0d_seg: got %h want %h", e.idx, bad_seg, e.seg);
        end
        if (dig_bad) begin
            errors++;
            $display("FAIL slot%0d_dig: got %h want %h", e.idx, bad_dig, e.dig);
        end
        if (idx_bad) begin
            errors++;
            $display("FAIL slot%0d_digit_idx: got %0d want %0d", e.idx, bad_idx, e.idx);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; enable = 1'b0; bright = 4'd0; frame_in = '0; frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (seg !== 8'h00)        begin errors++; $display("FAIL reset_seg: got %h want 00", seg); end
        if (dig !== 4'hF)         begin errors++; $display("FAIL reset_dig: got %h want f", dig); end
        if (digit_idx !== 2'd0)   begin errors++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", frame_ready); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame_full();
        frame_in = 32'h3F06_5B4F; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL idle_promote_ready: got %b want 1", frame_ready); end
        bright = 4'd15; enable = 1'b1;
        wait_frame_start();
        expect_frame(32'h3F06_5B4F, 15);
        repeat (4) capture_slot(-1, 4'd0);
    endtask

    task automatic test_brightness();
        bright = 4'd7;
        wait_frame_start();
        expect_frame(32'h3F06_5B4F, 7);
        repeat (4) capture_slot(-1, 4'd0);
        bright = 4'd0;
        wait_frame_start();
        expect_frame(32'h3F06_5B4F, 0);
        repeat (4) capture_slot(-1, 4'd0);
    endtask

    task automatic test_bright_change();
        bright = 4'd15;
        wait_frame_start();
        sb.push_back('{idx: 2'd0, seg: 8'h4F, dig: 4'hE, on: 15});
        sb.push_back('{idx: 2'd1, seg: 8'h5B, dig: 4'hD, on: 3});
        capture_slot(10, 4'd3);
        capture_slot(-1, 4'd0);
        bright = 4'd15;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        wait_frame_start();
        repeat (40) @(negedge clk);
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL a_ready: got %b want 1", frame_ready); end
        frame_in = 32'h0102_0408; frame_valid = 1'b1;
        @(negedge clk);
        frame_in = 32'h8040_2010;
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL b_ready_low: got %b want 0", frame_ready); end
        while (frame_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (n !== 87) begin errors++; $display("FAIL ready_rise_delay: got %0d want 87", n); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL ready_at_boundary: got %b want 1", frame_start); end
        expect_frame(32'h0102_0408, 15);
        expect_frame(32'h8040_2010, 15);
        capture_slot(-1, 4'd0);
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL b_pending: got %b want 0", frame_ready); end
        repeat (3) capture_slot(-1, 4'd0);
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL b_swapped_ready: got %b want 1", frame_ready); end
        repeat (4) capture_slot(-1, 4'd0);
    endtask

    task automatic test_enable_drop();
        wait_frame_start();
        repeat (2 * SCAN_DIV + 5) @(negedge clk);
        checks += 2;
        if (dig !== 4'hB)       begin errors++; $display("FAIL d2_on_dig: got %h want b", dig); end
        if (digit_idx !== 2'd2) begin errors++; $display("FAIL d2_on_idx: got %0d want 2", digit_idx); end
        enable = 1'b0;
        @(negedge clk);
        checks += 3;
        if (dig !== 4'hF)       begin errors++; $display("FAIL drop_dig: got %h want f", dig); end
        if (seg !== 8'h00)      begin errors++; $display("FAIL drop_seg: got %h want 00", seg); end
        if (digit_idx !== 2'd0) begin errors++; $display("FAIL drop_idx: got %0d want 0", digit_idx); end
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        checks += 2;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL reenable_pulse: got %b want 1", frame_start); end
        if (dig !== 4'hF)         begin errors++; $display("FAIL reenable_blank: got %h want f", dig); end
        expect_frame(32'h8040_2010, 15);
        repeat (4) capture_slot(-1, 4'd0);
    endtask

    task automatic test_async_reset();
        repeat (5) @(negedge clk);
        frame_in = 32'hDEAD_BEEF; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        checks += 2;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_pending: got %b want 0", frame_ready); end
        if (dig !== 4'hE)         begin errors++; $display("FAIL pre_reset_on: got %h want e", dig); end
        #2 nrst = 1'b0;
        #1;
        checks += 4;
        if (seg !== 8'h00)        begin errors++; $display("FAIL async_seg: got %h want 00", seg); end
        if (dig !== 4'hF)         begin errors++; $display("FAIL async_dig: got %h want f", dig); end
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b want 1", frame_ready); end
        if (digit_idx !== 2'd0)   begin errors++; $display("FAIL async_idx: got %0d want 0", digit_idx); end
        @(negedge clk);
        nrst = 1'b1;
        wait_frame_start();
        sb.push_back('{idx: 2'd0, seg: 8'h00, dig: 4'hE, on: 15});
        capture_slot(-1, 4'd0);
    endtask

    initial begin
        test_reset();
        test_frame_full();
        test_brightness();
        test_bright_change();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
